ipml_fifo_rd_stream_v1_0: RTL and testbench

Read-side drain engine for the 16-in/64-out asynchronous FIFO. Lives in the FIFO's read clock domain, issues rd_en against rd_empty, and absorbs the FIFO's fixed read latency in a small skid buffer. Presents the 64-bit words as a valid/ready stream with a periodic last marker for the downstream conv datapath. Provides a synchronous flush and a count of accepted beats.

---
 rtl/ipml_fifo_rd_pkg.sv | 36 +++
 rtl/ipml_fifo_rd_skid_buf.sv | 69 ++++++
 rtl/ipml_fifo_rd_stream_v1_0.sv | 124 ++++++++++++
 tb/tb_ipml_fifo_rd_stream_v1_0.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipml_fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side stream engine.
//   RD_LATENCY_MAX : largest supported FIFO rd_en-to-rd_data latency
//   depth_f        : skid buffer depth for a given read latency
//   clog2_f        : ceiling log2 for pointer sizing
//   params_ok      : elaboration-time legality check of top parameters
package ipml_fifo_rd_pkg;

  localparam int unsigned RD_LATENCY_MAX = 2;
  localparam int unsigned BURST_LEN_MAX  = 65535;

  // One slot per in-flight read plus one so a word can be presented while
  // the pipe refills; this is what allows 1 beat/cycle.
  function automatic int unsigned depth_f(input int unsigned rd_latency);
    return rd_latency + 1;
  endfunction

  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit params_ok(input int unsigned data_width,
                                   input int unsigned rd_latency,
                                   input int unsigned burst_len,
                                   input int unsigned cnt_width);
    return (data_width >= 1) &&
           (rd_latency >= 1) && (rd_latency <= RD_LATENCY_MAX) &&
           (burst_len >= 1) && (burst_len <= BURST_LEN_MAX) &&
           (cnt_width >= 1);
  endfunction

endpackage

// File: rtl/ipml_fifo_rd_skid_buf.sv
// Circular skid buffer absorbing the FIFO read latency.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : synchronous clear, dominates push/pop
//   i_push, i_data : write i_data at the tail
//   i_pop          : retire the head entry
//   o_data         : head entry (undefined when o_valid=0)
//   o_valid        : buffer not empty
//   o_level        : occupancy 0..DEPTH
module ipml_fifo_rd_skid_buf
  import ipml_fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic [1:0]            o_level
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? clog2_f(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [1:0]       LVL_FULL = 2'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [1:0]            r_level;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign w_do_push = i_push & (r_level != LVL_FULL);
  assign w_do_pop  = i_pop & (r_level != 2'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 2'd1;
        2'b01:   r_level <= r_level - 2'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while o_valid=1.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_clr) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_level != 2'd0);
  assign o_level = r_level;

endmodule

// File: rtl/ipml_fifo_rd_stream_v1_0.sv
// Read-side drain engine for the 16-in/64-out asynchronous FIFO.
// Issues FIFO reads under a credit rule, tracks reads in flight through the
// FIFO latency, buffers returned words and presents them as a valid/ready
// stream with a periodic last marker and a running beat count.
//   rd_clk, rd_rst_n     : read clock, asynchronous active-low reset
//   flush                : synchronous flush, active high
//   fifo_rd_en           : FIFO read enable (never while fifo_rd_empty=1)
//   fifo_rd_empty        : FIFO empty flag
//   fifo_rd_data         : FIFO read data, RD_LATENCY cycles after rd_en
//   m_valid/m_ready      : output stream handshake
//   m_data, m_last       : output beat data (0 when idle), end-of-burst marker
//   buf_level            : skid buffer occupancy
//   beat_total           : accepted beats since reset/flush, wrapping
module ipml_fifo_rd_stream_v1_0
  import ipml_fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  flush,
  output logic                  fifo_rd_en,
  input  logic                  fifo_rd_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [1:0]            buf_level,
  output logic [CNT_WIDTH-1:0]  beat_total
);

  localparam int unsigned DEPTH    = depth_f(RD_LATENCY);
  localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

  if (!params_ok(DATA_WIDTH, RD_LATENCY, BURST_LEN, CNT_WIDTH)) begin : g_bad_params
    $error("ipml_fifo_rd_stream_v1_0: illegal parameter combination");
  end

  logic [RD_LATENCY-1:0] r_pipe;
  logic [RD_LATENCY-1:0] w_pipe_shift;
  logic [1:0]            w_inflight;
  logic [2:0]            w_occupancy;
  logic                  w_credit;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_head_valid;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [1:0]            w_level;
  logic [15:0]           r_idx;
  logic [CNT_WIDTH-1:0]  r_beat_total;

  assign w_pop  = w_head_valid & m_ready;
  assign w_push = r_pipe[RD_LATENCY-1];

  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + 2'(r_pipe[i]);
    end
  end

  // Words already owned by this block after the edge (buffered + in flight,
  // less the one leaving now); a new read is allowed only if it still fits.
  assign w_occupancy = 3'(w_level) + 3'(w_inflight) - 3'(w_pop);
  assign w_credit    = (w_occupancy < 3'(DEPTH));

  // Gated by rd_rst_n so no read is issued while held in reset.
  assign fifo_rd_en = rd_rst_n & ~fifo_rd_empty & ~flush & w_credit;

  if (RD_LATENCY == 1) begin : g_lat1
    assign w_pipe_shift = fifo_rd_en;
  end else begin : g_latn
    assign w_pipe_shift = {r_pipe[RD_LATENCY-2:0], fifo_rd_en};
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_pipe <= '0;
    end else if (flush) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= w_pipe_shift;
    end
  end

  ipml_fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_skid (
    .i_clk   (rd_clk),
    .i_rst_n (rd_rst_n),
    .i_clr   (flush),
    .i_push  (w_push),
    .i_data  (fifo_rd_data),
    .i_pop   (w_pop),
    .o_data  (w_head_data),
    .o_valid (w_head_valid),
    .o_level (w_level)
  );

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_idx        <= '0;
      r_beat_total <= '0;
    end else if (flush) begin
      r_idx        <= '0;
      r_beat_total <= '0;
    end else if (w_pop) begin
      r_idx        <= (r_idx == LAST_IDX) ? '0 : r_idx + 16'd1;
      r_beat_total <= r_beat_total + CNT_WIDTH'(1);
    end
  end

  assign m_valid    = w_head_valid;
  assign m_data     = w_head_valid ? w_head_data : '0;
  assign m_last     = w_head_valid & (r_idx == LAST_IDX);
  assign buf_level  = w_level;
  assign beat_total = r_beat_total;

endmodule

// File: tb/tb_ipml_fifo_rd_stream_v1_0.sv
module tb_ipml_fifo_rd_stream_v1_0;

  localparam int unsigned DW    = 64;
  localparam int unsigned RDL   = 2;
  localparam int unsigned BL    = 4;
  localparam int unsigned CW    = 32;
  localparam int unsigned DEPTH = RDL + 1;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n;
  logic          flush;
  logic          fifo_rd_en;
  logic          fifo_rd_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [1:0]    buf_level;
  logic [CW-1:0] beat_total;

  always #5 rd_clk = ~rd_clk;

  ipml_fifo_rd_stream_v1_0 #(
    .DATA_WIDTH (DW),
    .RD_LATENCY (RDL),
    .BURST_LEN  (BL),
    .CNT_WIDTH  (CW)
  ) dut (
    .rd_clk        (rd_clk),
    .rd_rst_n      (rd_rst_n),
    .flush         (flush),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_empty (fifo_rd_empty),
    .fifo_rd_data  (fifo_rd_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .buf_level     (buf_level),
    .beat_total    (beat_total)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  // Reference model: FIFO contents, FIFO read-latency pipe, and the list of
  // words fetched from the FIFO but not yet delivered downstream.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] lat_pipe[RDL];
  int unsigned   beats;
  logic          hold_prev;
  logic [DW-1:0] data_prev;
  int unsigned   n_rden;
  int unsigned   n_pop;
  int unsigned   seq;

  typedef struct {
    logic        ready;
    logic        flush;
    logic        valid;
    logic        last;
    logic [1:0]  level;
    logic        rd_en;
    int unsigned bt;
    logic [63:0] data;
  } vec_t;
  vec_t vtab[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] tword(input int unsigned n);
    return {32'hC0DE_0000 | n, 32'h1234_5678 ^ n};
  endfunction

  task automatic add_words(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      fifo_q.push_back({seq, $urandom()});
      seq++;
    end
    fifo_rd_empty = (fifo_q.size() == 0);
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic step();
    logic en, pop, fl;
    logic [DW-1:0] w;
    chk("rd_en_while_empty", 64'(fifo_rd_en & fifo_rd_empty), 64'd0);
    chk("fetched_within_depth", 64'(exp_q.size() <= DEPTH), 64'd1);
    chk("beat_total", 64'(beat_total), 64'(beats));
    if (m_valid) begin
      if (exp_q.size() == 0) chk("spurious_beat", 64'd1, 64'd0);
      else                   chk("m_data", m_data, exp_q[0]);
      chk("m_last", 64'(m_last), 64'((beats % BL) == BL - 1));
    end else begin
      chk("m_data_idle", m_data, 64'd0);
      chk("m_last_idle", 64'(m_last), 64'd0);
    end
    if (hold_prev) begin
      chk("hold_valid", 64'(m_valid), 64'd1);
      chk("hold_data", m_data, data_prev);
    end
    en        = fifo_rd_en;
    pop       = m_valid & m_ready;
    fl        = flush;
    hold_prev = m_valid & ~m_ready & ~fl;
    data_prev = m_data;
    @(posedge rd_clk);
    #1;
    if (fl) begin
      exp_q.delete();
      beats = 0;
    end else if (pop) begin
      w = exp_q.pop_front();
      beats++;
      n_pop++;
    end
    for (int i = RDL - 1; i > 0; i--) lat_pipe[i] = lat_pipe[i-1];
    lat_pipe[0] = {$urandom(), $urandom()};
    if (en) begin
      w = fifo_q.pop_front();
      lat_pipe[0] = w;
      exp_q.push_back(w);
      n_rden++;
    end
    fifo_rd_data  = lat_pipe[RDL-1];
    fifo_rd_empty = (fifo_q.size() == 0);
  endtask

  task automatic cyc(input logic rdy, input logic fl);
    m_ready = rdy;
    flush   = fl;
    #1;
    step();
  endtask

  task automatic drain(input string tag);
    bit done;
    done    = 1'b0;
    m_ready = 1'b1;
    flush   = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      #1;
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !m_valid) done = 1'b1;
      else step();
    end
    chk({tag, "_drained"}, 64'(done), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rd_rst_n      = 1'b0;
    flush         = 1'b0;
    m_ready       = 1'b0;
    fifo_rd_empty = 1'b1;
    fifo_rd_data  = '0;
    beats         = 0;
    hold_prev     = 1'b0;
    data_prev     = '0;
    n_rden        = 0;
    n_pop         = 0;
    seq           = 32'h100;
    for (int i = 0; i < RDL; i++) lat_pipe[i] = '0;

    // Startup + streaming: 12 words present at release, m_ready=1.
    // First beat RD_LATENCY+1 cycles after reads start, last on beats 3/7/11.
    vtab[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 0,  64'd0};
    vtab[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 0,  64'd0};
    vtab[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 0,  64'd0};
    vtab[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 0,  tword(0)};
    vtab[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1,  tword(1)};
    vtab[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 2,  tword(2)};
    vtab[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 3,  tword(3)};
    vtab[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 4,  tword(4)};
    vtab[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 5,  tword(5)};
    vtab[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 6,  tword(6)};
    vtab[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 7,  tword(7)};
    vtab[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 8,  tword(8)};
    vtab[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 9,  tword(9)};
    vtab[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 10, tword(10)};
    vtab[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 11, tword(11)};
    vtab[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 12, 64'd0};

    // Reset held with the FIFO non-empty.
    repeat (2) @(posedge rd_clk);
    #1;
    for (int unsigned i = 0; i < 12; i++) fifo_q.push_back(tword(i));
    fifo_rd_empty = 1'b0;
    m_ready       = 1'b1;
    #1;
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_beat_total", 64'(beat_total), 64'd0);
    chk("rst_buf_level", 64'(buf_level), 64'd0);
    @(posedge rd_clk);
    #1;
    chk("rst_hold_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_hold_m_valid", 64'(m_valid), 64'd0);
    rd_rst_n = 1'b1;

    for (int c = 0; c < 16; c++) begin
      m_ready = vtab[c].ready;
      flush   = vtab[c].flush;
      #1;
      chk($sformatf("tab%0d_m_valid", c), 64'(m_valid), 64'(vtab[c].valid));
      chk($sformatf("tab%0d_m_last", c), 64'(m_last), 64'(vtab[c].last));
      chk($sformatf("tab%0d_buf_level", c), 64'(buf_level), 64'(vtab[c].level));
      chk($sformatf("tab%0d_rd_en", c), 64'(fifo_rd_en), 64'(vtab[c].rd_en));
      chk($sformatf("tab%0d_beat_total", c), 64'(beat_total), 64'(vtab[c].bt));
      chk($sformatf("tab%0d_m_data", c), m_data, vtab[c].data);
      step();
    end

    // Backpressure: reads stop once buffer+pipe hold DEPTH words.
    add_words(20);
    repeat (4) cyc(1'b1, 1'b0);
    repeat (10) cyc(1'b0, 1'b0);
    #1;
    chk("bp_buf_level", 64'(buf_level), 64'(DEPTH));
    chk("bp_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("bp_m_valid", 64'(m_valid), 64'd1);
    drain("backpressure");

    // Empty edge: a single word gives one read and one beat.
    n_rden = 0;
    n_pop  = 0;
    add_words(1);
    repeat (8) cyc(1'b1, 1'b0);
    chk("single_rd_en_pulses", 64'(n_rden), 64'd1);
    chk("single_beats", 64'(n_pop), 64'd1);

    // Flush while streaming: one buffered, two in flight.
    add_words(30);
    repeat (6) cyc(1'b1, 1'b0);
    m_ready = 1'b1;
    flush   = 1'b1;
    #1;
    chk("flush_cycle_rd_en", 64'(fifo_rd_en), 64'd0);
    step();
    flush = 1'b0;
    #1;
    chk("post_flush_m_valid", 64'(m_valid), 64'd0);
    chk("post_flush_buf_level", 64'(buf_level), 64'd0);
    chk("post_flush_beat_total", 64'(beat_total), 64'd0);
    drain("flush");

    // Alternating ready with the buffer near full.
    add_words(16);
    repeat (4) cyc(1'b0, 1'b0);
    for (int c = 0; c < 24; c++) cyc(c[0], 1'b0);
    drain("alternate");

    // Randomized traffic, backpressure and occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) add_words($urandom_range(2));
      cyc(($urandom_range(2) != 0), ($urandom_range(79) == 0));
    end
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
